mem_io_responder: RTL

//  Responder (target) side of the CPU memory bus (mem_addr/mem_rdata/mem_rstrb/mem_wdata/mem_wmask).

---
 rtl/mem_io_responder_pkg.sv | 27 ++
 rtl/mem_io_responder_uart_tx_serializer.sv | 78 +++++++
 rtl/mem_io_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared IO-page map: register indices, STATUS bit positions and serializer states.
// The firmware side uses the same index and bit constants.
package mem_io_responder_pkg;

  localparam int IO_BIT_DEFAULT = 22;

  typedef enum logic [1:0] {
    IDX_LEDS        = 2'd0,
    IDX_UART_DATA   = 2'd1,
    IDX_UART_STATUS = 2'd2,
    IDX_CYCLES      = 2'd3
  } io_idx_e;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/mem_io_responder_uart_tx_serializer.sv
// 8N1 serializer: pops one byte from the TX FIFO when idle and shifts it out LSB first.
module uart_tx_serializer
  import mem_io_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_byte,
  output logic       pop,
  output logic       active,
  output logic       txd
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state, state_nxt;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              bit_done;

  assign bit_done = (baud == BAUD_LAST);
  assign active   = (state != TX_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= TX_IDLE;
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    else         state <= state_nxt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == TX_IDLE || bit_done) baud <= '0;
      else                              baud <= baud + BAUD_W'(1);

      if (pop)                              shreg <= fifo_byte;
      else if (state == TX_DATA && bit_done) shreg <= {1'b0, shreg[7:1]};

      if (state == TX_START)                 bit_idx <= '0;
      else if (state == TX_DATA && bit_done) bit_idx <= bit_idx + 3'd1;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    state_nxt = state;
    pop       = 1'b0;
    txd       = 1'b1;
    unique case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = TX_START;
        end
      end
      TX_START: begin
        txd = 1'b0;
        if (bit_done) state_nxt = TX_DATA;
      end
      TX_DATA: begin
        txd = shreg[0];
        if (bit_done && bit_idx == 3'd7) state_nxt = TX_STOP;
      end
      TX_STOP: begin
        if (bit_done) state_nxt = TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_io_responder.sv
// IO-page responder on the CPU memory bus: LED register, UART TX with FIFO, cycle counter.
// io_rdata is registered; the SOC muxes it against RAM using a registered IO-select bit.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int IO_BIT       = IO_BIT_DEFAULT,
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] mem_addr,
  input  logic        mem_rstrb,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [31:0] io_rdata,
  output logic [4:0]  leds,
  output logic        uart_txd
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  io_idx_e          idx;
  logic             io_sel, wr_en, rd_en;
  logic             push_req, push, pop, full, empty;
  logic             overflow, overflow_set, overflow_clr;
  logic             ser_active;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      cycles, status, rdata_nxt;
  logic             unused_bits;

  assign io_sel = mem_addr[IO_BIT];
  assign idx    = io_idx_e'(mem_addr[3:2]);
  assign wr_en  = io_sel & (|mem_wmask);
  assign rd_en  = io_sel & mem_rstrb;

  // Address bits outside the decode and upper write-data bits are don't-care.
  assign unused_bits = ^{mem_addr, mem_wdata};

  // ---------------- TX FIFO ----------------
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_req = wr_en & (idx == IDX_UART_DATA) & mem_wmask[0];
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push     = push_req & (~full | pop);

  assign overflow_set = push_req & full & ~pop;
  assign overflow_clr = rd_en & (idx == IDX_UART_STATUS);

  // NOTE: the storage array has no reset; only pointers and count define its contents.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (overflow_set)      overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clock      (clock),
    .resetn     (resetn),
    .fifo_empty (empty),
    .fifo_byte  (fifo_mem[rd_ptr]),
    .pop        (pop),
    .active     (ser_active),
    .txd        (uart_txd)
  );

  // ---------------- registers ----------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      leds     <= '0;
      cycles   <= '0;
      io_rdata <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (wr_en && idx == IDX_LEDS && mem_wmask[0]) leds <= mem_wdata[4:0];
      if (rd_en) io_rdata <= rdata_nxt;
    end
  end

  always_comb begin
    status                             = '0;
    status[STAT_BUSY]                  = ser_active | ~empty;
    status[STAT_FULL]                  = full;
    status[STAT_EMPTY]                 = empty;
    status[STAT_OVERFLOW]              = overflow;
    status[STAT_COUNT_LSB +: CNT_W]    = count;
  end

  always_comb begin
    rdata_nxt = '0;
    unique case (idx)
      IDX_LEDS:        rdata_nxt = {27'd0, leds};
      IDX_UART_DATA:   rdata_nxt = '0;
      IDX_UART_STATUS: rdata_nxt = status;
      IDX_CYCLES:      rdata_nxt = cycles;
      default:         rdata_nxt = '0;
    endcase
  end

endmodule
